// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared defaults and width helper for the channel router sync block
package router_pkg;

    localparam int DEF_NUM_CH  = 3;
    localparam int DEF_TIMEOUT = 30;

    // Bits needed to encode values 0..n-1; never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/router_sync_timer.sv
// rtl/router_sync_timer.sv - per-channel idle-valid timeout counter with single-cycle flush pulse
module router_sync_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    localparam int                CNT_W = clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // The pulse is registered from the same decision that restarts the count,
    // so a read landing in the pulse cycle only affects the next count window.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (!vld || rd) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (cnt == LAST) begin
            cnt        <= '0;
            soft_reset <= 1'b1;
        end else begin
            cnt        <= cnt + 1'b1;
            soft_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/router_sync_nch.sv
// rtl/router_sync_nch.sv - address latch, one-hot write decode, full mux and per-channel timeouts
module router_sync_nch
    import router_pkg::*;
#(
    parameter  int NUM_CH  = DEF_NUM_CH,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int ADDR_W  = clog2(NUM_CH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] read_enb,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
);

    logic [ADDR_W-1:0] addr_q;
    logic              addr_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q  <= '0;
            addr_ok <= 1'b1;
        end else if (detect_add) begin
            addr_q  <= data_in;
            addr_ok <= (int'(data_in) < NUM_CH);
        end
    end

    // Scanning legal channel indices keeps an out-of-range address from
    // ever selecting a bit of full or write_enb.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_ok && (addr_q == ADDR_W'(i))) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    assign addr_err = ~addr_ok;
    assign vld_out  = ~empty;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
        router_sync_timer #(
            .TIMEOUT (TIMEOUT)
        ) u_timer (
            .clock      (clock),
            .reset      (reset),
            .vld        (vld_out[g]),
            .rd         (read_enb[g]),
            .soft_reset (soft_reset[g])
        );
    end

endmodule

// File: tb/tb_router_sync_nch.sv
// tb/tb_router_sync_nch.sv - directed self-checking bench for router_sync_nch
module tb_router_sync_nch;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic       a_detect, a_wreg, a_ff, a_err;
    logic [1:0] a_data;
    logic [2:0] a_rd, a_empty, a_full, a_we, a_vld, a_sr;

    logic       b_detect, b_wreg, b_ff, b_err;
    logic [1:0] b_data;
    logic [3:0] b_rd, b_empty, b_full, b_we, b_vld, b_sr;

    int tests = 0;
    int fails = 0;

    router_sync_nch #(.NUM_CH(3), .TIMEOUT(30)) u_a (
        .clock(clock), .reset(reset), .detect_add(a_detect), .data_in(a_data),
        .write_enb_reg(a_wreg), .read_enb(a_rd), .empty(a_empty), .full(a_full),
        .write_enb(a_we), .fifo_full(a_ff), .vld_out(a_vld), .soft_reset(a_sr),
        .addr_err(a_err)
    );

    router_sync_nch #(.NUM_CH(4), .TIMEOUT(5)) u_b (
        .clock(clock), .reset(reset), .detect_add(b_detect), .data_in(b_data),
        .write_enb_reg(b_wreg), .read_enb(b_rd), .empty(b_empty), .full(b_full),
        .write_enb(b_we), .fifo_full(b_ff), .vld_out(b_vld), .soft_reset(b_sr),
        .addr_err(b_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        a_detect = 1'b0; a_data = 2'b00; a_wreg = 1'b0; a_rd = '0;
        a_empty  = 3'b111; a_full = 3'b001;
        b_detect = 1'b0; b_data = 2'b00; b_wreg = 1'b0; b_rd = '0;
        b_empty  = 4'b1111; b_full = 4'b0001;
        tick;
        tick;
        reset = 1'b0;
        #1;

        chk("rst_a_we",  a_we,  3'b000);
        chk("rst_a_err", a_err, 1'b0);
        chk("rst_a_sr",  a_sr,  3'b000);
        chk("rst_a_ff",  a_ff,  1'b1);
        chk("rst_a_vld", a_vld, 3'b000);
        chk("rst_b_ff",  b_ff,  1'b1);
        chk("rst_b_err", b_err, 1'b0);
        a_wreg = 1'b1;
        #1;
        chk("rst_a_we_ch0", a_we, 3'b001);
        a_wreg = 1'b0;

        a_detect = 1'b1; a_data = 2'b01;
        tick;
        a_detect = 1'b0; a_wreg = 1'b1;
        #1;
        chk("dec_ch1_we",  a_we,  3'b010);
        chk("dec_ch1_err", a_err, 1'b0);

        a_detect = 1'b1; a_data = 2'b00;
        #1;
        chk("dec_same_cycle_old_addr", a_we, 3'b010);
        tick;
        a_detect = 1'b0;
        #1;
        chk("dec_new_addr_ch0", a_we, 3'b001);

        a_detect = 1'b1; a_data = 2'b01;
        tick;
        a_detect = 1'b0;
        a_full = 3'b010;
        #1;
        chk("full_ch1_set", a_ff, 1'b1);
        a_full = 3'b101;
        #1;
        chk("full_ch1_clr", a_ff, 1'b0);

        a_detect = 1'b1; a_data = 2'b11;
        tick;
        a_detect = 1'b0; a_full = 3'b111;
        #1;
        chk("bad_addr_we",  a_we,  3'b000);
        chk("bad_addr_err", a_err, 1'b1);
        chk("bad_addr_ff",  a_ff,  1'b0);
        a_wreg = 1'b0;
        tick;
        chk("bad_addr_err_held", a_err, 1'b1);

        a_empty = 3'b101;
        #1;
        chk("vld_a", a_vld, 3'b010);
        for (int k = 1; k <= 60; k++) begin
            tick;
            chk($sformatf("to_a_%0d", k), a_sr, (k % 30 == 0) ? 3'b010 : 3'b000);
        end
        a_rd = 3'b010;
        tick;
        a_rd = 3'b000;
        chk("pulse_single_with_read", a_sr, 3'b000);

        a_empty = 3'b111;
        tick;
        a_empty = 3'b101;
        for (int k = 1; k <= 50; k++) begin
            a_rd = (k == 20) ? 3'b010 : 3'b000;
            tick;
            chk($sformatf("rd_restart_%0d", k), a_sr, (k == 50) ? 3'b010 : 3'b000);
        end
        a_rd = 3'b000;

        a_empty = 3'b111;
        tick;
        a_empty = 3'b101;
        for (int k = 1; k <= 55; k++) begin
            reset = (k == 25);
            tick;
            chk($sformatf("rst_mid_%0d", k), a_sr, (k == 55) ? 3'b010 : 3'b000);
        end
        reset = 1'b0;

        b_empty = 4'b0000;
        for (int k = 1; k <= 15; k++) begin
            tick;
            chk($sformatf("to_b_%0d", k), b_sr, (k % 5 == 0) ? 4'b1111 : 4'b0000);
        end

        b_detect = 1'b1; b_data = 2'b11;
        tick;
        b_detect = 1'b0; b_wreg = 1'b1; b_full = 4'b1000;
        #1;
        chk("b_ch3_we",  b_we,  4'b1000);
        chk("b_ch3_err", b_err, 1'b0);
        chk("b_ch3_ff",  b_ff,  1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
